// File: rtl/urv_dm_arbiter.sv
// Data-memory port arbiter: the core (c_*) has fixed priority over a host/debug master (h_*).
// A wait counter gives a starved host one grant; a bus timeout terminates unacknowledged transfers.
module urv_dm_arbiter #(
    parameter int unsigned HOST_MAX_WAIT = 16,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_i,
    input  logic [3:0]  c_sel_i,
    output logic        c_ack_o,
    output logic        c_err_o,
    output logic [31:0] c_rdata_o,
    input  logic        h_req_i,
    input  logic        h_we_i,
    input  logic [31:0] h_addr_i,
    input  logic [31:0] h_data_i,
    input  logic [3:0]  h_sel_i,
    output logic        h_ack_o,
    output logic        h_err_o,
    output logic [31:0] h_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);
    typedef enum logic [1:0] {StIdle, StCore, StHost, StDone} state_e;

    localparam logic [7:0]  WaitMax = 8'(HOST_MAX_WAIT);
    localparam logic [15:0] ToLast  = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] to_q, to_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic        c_ack_q, c_ack_d, c_err_q, c_err_d;
    logic        h_ack_q, h_ack_d, h_err_q, h_err_d;
    logic [31:0] c_rdata_q, c_rdata_d, h_rdata_q, h_rdata_d;
    logic        host_win, to_hit, owner_host;

    assign host_win   = h_req_i && ((wait_q == WaitMax) || !c_req_i);
    assign to_hit     = (TIMEOUT != 0) && (to_q == ToLast);
    assign owner_host = (state_q == StHost);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        to_d       = to_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_sel_d  = mem_sel_q;
        c_ack_d    = 1'b0;
        c_err_d    = 1'b0;
        h_ack_d    = 1'b0;
        h_err_d    = 1'b0;
        c_rdata_d  = c_rdata_q;
        h_rdata_d  = h_rdata_q;

        if (!h_req_i) begin
            wait_d = '0;
        end else if (!owner_host && (wait_q != WaitMax)) begin
            wait_d = wait_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (host_win) begin
                    state_d    = StHost;
                    mem_req_d  = 1'b1;
                    mem_we_d   = h_we_i;
                    mem_addr_d = h_addr_i;
                    mem_data_d = h_data_i;
                    mem_sel_d  = h_sel_i;
                    to_d       = '0;
                    wait_d     = '0;
                end else if (c_req_i) begin
                    state_d    = StCore;
                    mem_req_d  = 1'b1;
                    mem_we_d   = c_we_i;
                    mem_addr_d = c_addr_i;
                    mem_data_d = c_data_i;
                    mem_sel_d  = c_sel_i;
                    to_d       = '0;
                end
            end
            StCore, StHost: begin
                // A bus ack in the timeout cycle takes precedence over the error.
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                    if (owner_host) begin
                        h_ack_d = 1'b1;
                        if (!mem_we_q) h_rdata_d = mem_data_i;
                    end else begin
                        c_ack_d = 1'b1;
                        if (!mem_we_q) c_rdata_d = mem_data_i;
                    end
                end else if (to_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                    if (owner_host) begin
                        h_ack_d   = 1'b1;
                        h_err_d   = 1'b1;
                        h_rdata_d = '0;
                    end else begin
                        c_ack_d   = 1'b1;
                        c_err_d   = 1'b1;
                        c_rdata_d = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    to_d = to_q + 16'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            to_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_sel_q  <= '0;
            c_ack_q    <= 1'b0;
            c_err_q    <= 1'b0;
            h_ack_q    <= 1'b0;
            h_err_q    <= 1'b0;
            c_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            to_q       <= to_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_sel_q  <= mem_sel_d;
            c_ack_q    <= c_ack_d;
            c_err_q    <= c_err_d;
            h_ack_q    <= h_ack_d;
            h_err_q    <= h_err_d;
            c_rdata_q  <= c_rdata_d;
            h_rdata_q  <= h_rdata_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_sel_o  = mem_sel_q;
    assign c_ack_o    = c_ack_q;
    assign c_err_o    = c_err_q;
    assign c_rdata_o  = c_rdata_q;
    assign h_ack_o    = h_ack_q;
    assign h_err_o    = h_err_q;
    assign h_rdata_o  = h_rdata_q;
endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Bench for urv_dm_arbiter: a memory responder with programmable latency plus an ordered
// scoreboard of expected grants and completions.
module tb_urv_dm_arbiter;
    typedef struct {
        bit          host;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic        c_req_i = 1'b0, c_we_i = 1'b0, h_req_i = 1'b0, h_we_i = 1'b0;
    logic [31:0] c_addr_i = '0, c_data_i = '0, h_addr_i = '0, h_data_i = '0;
    logic [3:0]  c_sel_i = '0, h_sel_i = '0;
    logic        c_ack_o, c_err_o, h_ack_o, h_err_o;
    logic [31:0] c_rdata_o, h_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = '0;

    int          checks = 0, failures = 0, cyc = 0;
    int          mem_lat = -1, mem_cnt = 0;
    logic [31:0] mem_rd = '0;
    bit          req_prev = 1'b0;
    int          rise_cyc = -1, req_len = 0, last_len = -1, last_ack_cyc = -1;
    exp_t        sb[$];
    exp_t        e;
    logic [3:0]  exp_flags;
    logic [31:0] got_rd;

    urv_dm_arbiter #(.HOST_MAX_WAIT(4), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_data_i(c_data_i),
        .c_sel_i(c_sel_i), .c_ack_o(c_ack_o), .c_err_o(c_err_o), .c_rdata_o(c_rdata_o),
        .h_req_i(h_req_i), .h_we_i(h_we_i), .h_addr_i(h_addr_i), .h_data_i(h_data_i),
        .h_sel_i(h_sel_i), .h_ack_o(h_ack_o), .h_err_o(h_err_o), .h_rdata_o(h_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o), .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i)
    );

    initial forever #5 clk_i = ~clk_i;
    initial forever begin @(posedge clk_i); cyc++; end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected TB_RESULT before it");
        $fatal(1);
    end

    // Memory responder, episode log and scoreboard, all sampled on the falling edge.
    initial forever begin
        @(negedge clk_i);
        if (mem_req_o) begin
            if (!req_prev) begin
                rise_cyc = cyc;
                req_len  = 0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected: addr=%h, expected no grant", mem_addr_o);
                end else if ({mem_we_o, mem_addr_o, mem_data_o, mem_sel_o} !==
                             {sb[0].we, sb[0].addr, sb[0].data, sb[0].sel}) begin
                    failures++;
                    $display("FAIL grant_fields: got we=%b addr=%h data=%h sel=%b, expected we=%b addr=%h data=%h sel=%b",
                             mem_we_o, mem_addr_o, mem_data_o, mem_sel_o,
                             sb[0].we, sb[0].addr, sb[0].data, sb[0].sel);
                end
            end
            req_len++;
            mem_ack_i = (mem_lat >= 0) && (mem_cnt == mem_lat);
            if (mem_ack_i) last_ack_cyc = cyc;
            mem_cnt++;
        end else begin
            if (req_prev) last_len = req_len;
            mem_ack_i = 1'b0;
            mem_cnt   = 0;
        end
        mem_data_i = mem_rd;
        req_prev   = mem_req_o;
        if (c_ack_o || h_ack_o) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL ack_unexpected: c_ack=%b h_ack=%b, expected none", c_ack_o, h_ack_o);
            end else begin
                e = sb.pop_front();
                exp_flags = e.host ? {2'b00, 1'b1, e.err} : {1'b1, e.err, 2'b00};
                got_rd    = e.host ? h_rdata_o : c_rdata_o;
                if ({c_ack_o, c_err_o, h_ack_o, h_err_o} !== exp_flags || got_rd !== e.rdata) begin
                    failures++;
                    $display("FAIL ack_result: got c_ack/err h_ack/err=%b rdata=%h, expected %b rdata=%h",
                             {c_ack_o, c_err_o, h_ack_o, h_err_o}, got_rd, exp_flags, e.rdata);
                end
            end
        end
    end

    task automatic wait_ack(input bit host, input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            if (host ? h_ack_o : c_ack_o) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic drive_core(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] data);
        c_req_i = req; c_we_i = we; c_addr_i = addr; c_data_i = data; c_sel_i = 4'hF;
    endtask

    task automatic drive_host(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] data);
        h_req_i = req; h_we_i = we; h_addr_i = addr; h_data_i = data; h_sel_i = 4'hF;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o} !== '0) begin
            failures++;
            $display("FAIL reset_mem: got req=%b addr=%h, expected all 0", mem_req_o, mem_addr_o);
        end
        checks++;
        if ({c_ack_o, c_err_o, c_rdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_core: got ack=%b rdata=%h, expected 0", c_ack_o, c_rdata_o);
        end
        checks++;
        if ({h_ack_o, h_err_o, h_rdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_host: got ack=%b rdata=%h, expected 0", h_ack_o, h_rdata_o);
        end
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
    endtask

    task automatic test_core_load();
        int n, at;
        bit ok;
        mem_lat = 2; mem_rd = 32'hCAFEBABE;
        @(posedge clk_i); #1;
        n = cyc;
        sb.push_back('{host: 1'b0, we: 1'b0, addr: 32'h100, data: 32'h0, sel: 4'hF,
                       rdata: 32'hCAFEBABE, err: 1'b0});
        drive_core(1'b1, 1'b0, 32'h100, 32'h0);
        wait_ack(1'b0, 20, ok, at);
        @(posedge clk_i); #1;
        c_req_i = 1'b0;
        checks++;
        if (!ok || at != n + 4) begin
            failures++;
            $display("FAIL core_load_ack_cycle: got %0d, expected %0d", at, n + 4);
        end
        checks++;
        if (rise_cyc != n + 1) begin
            failures++;
            $display("FAIL core_load_req_rise: got %0d, expected %0d", rise_cyc, n + 1);
        end
        checks++;
        if (last_len != 3) begin
            failures++;
            $display("FAIL core_load_req_len: got %0d, expected 3", last_len);
        end
        checks++;
        if ({h_ack_o, h_err_o, h_rdata_o} !== '0) begin
            failures++;
            $display("FAIL core_load_host_quiet: got ack=%b rdata=%h, expected 0", h_ack_o, h_rdata_o);
        end
    endtask

    task automatic test_contention();
        int at, core_ack;
        bit ok1, ok2;
        mem_lat = 1; mem_rd = 32'h5555AAAA;
        @(posedge clk_i); #1;
        sb.push_back('{host: 1'b0, we: 1'b1, addr: 32'h104, data: 32'h11223344, sel: 4'hF,
                       rdata: 32'hCAFEBABE, err: 1'b0});
        sb.push_back('{host: 1'b1, we: 1'b0, addr: 32'h200, data: 32'h0, sel: 4'hF,
                       rdata: 32'h5555AAAA, err: 1'b0});
        drive_core(1'b1, 1'b1, 32'h104, 32'h11223344);
        drive_host(1'b1, 1'b0, 32'h200, 32'h0);
        wait_ack(1'b0, 20, ok1, at);
        @(posedge clk_i); #1;
        c_req_i  = 1'b0;
        core_ack = last_ack_cyc;
        wait_ack(1'b1, 20, ok2, at);
        @(posedge clk_i); #1;
        h_req_i = 1'b0;
        checks++;
        if (!ok1 || !ok2) begin
            failures++;
            $display("FAIL contention_acks: got core=%b host=%b, expected both 1", ok1, ok2);
        end
        checks++;
        if (rise_cyc != core_ack + 3) begin
            failures++;
            $display("FAIL contention_gap: host req at %0d, expected %0d", rise_cyc, core_ack + 3);
        end
        checks++;
        if (c_rdata_o !== 32'hCAFEBABE) begin
            failures++;
            $display("FAIL contention_core_rdata_hold: got %h, expected cafebabe", c_rdata_o);
        end
    endtask

    task automatic test_starvation();
        int n, at, at_h, hr;
        bit ok1, ok2, ok3, ok4;
        mem_lat = 0; mem_rd = 32'h0BADF00D;
        @(posedge clk_i); #1;
        n = cyc;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{host: (i == 2), we: 1'b0, addr: (i == 2) ? 32'h400 : 32'h300,
                           data: 32'h0, sel: 4'hF, rdata: 32'h0BADF00D, err: 1'b0});
        end
        drive_core(1'b1, 1'b0, 32'h300, 32'h0);
        drive_host(1'b1, 1'b0, 32'h400, 32'h0);
        wait_ack(1'b0, 20, ok1, at);
        wait_ack(1'b0, 20, ok2, at);
        wait_ack(1'b1, 20, ok3, at_h);
        @(posedge clk_i); #1;
        h_req_i = 1'b0;
        hr = rise_cyc;
        wait_ack(1'b0, 20, ok4, at);
        @(posedge clk_i); #1;
        c_req_i = 1'b0;
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4)) begin
            failures++;
            $display("FAIL starve_acks: got %b%b%b%b, expected 1111", ok1, ok2, ok3, ok4);
        end
        checks++;
        if (hr != n + 7 || at_h != n + 8) begin
            failures++;
            $display("FAIL starve_host_grant: req at %0d ack at %0d, expected %0d and %0d",
                     hr, at_h, n + 7, n + 8);
        end
    endtask

    task automatic test_timeout();
        int at;
        bit ok1, ok2;
        mem_lat = -1; mem_rd = 32'hDEADBEEF;
        @(posedge clk_i); #1;
        sb.push_back('{host: 1'b0, we: 1'b0, addr: 32'h500, data: 32'h0, sel: 4'hF,
                       rdata: 32'h0, err: 1'b1});
        drive_core(1'b1, 1'b0, 32'h500, 32'h0);
        wait_ack(1'b0, 30, ok1, at);
        @(posedge clk_i); #1;
        c_req_i = 1'b0;
        checks++;
        if (!ok1 || last_len != 8) begin
            failures++;
            $display("FAIL timeout_len: ack=%b req cycles=%0d, expected 1 and 8", ok1, last_len);
        end
        mem_lat = 1; mem_rd = 32'h12345678;
        sb.push_back('{host: 1'b0, we: 1'b0, addr: 32'h504, data: 32'h0, sel: 4'hF,
                       rdata: 32'h12345678, err: 1'b0});
        drive_core(1'b1, 1'b0, 32'h504, 32'h0);
        wait_ack(1'b0, 20, ok2, at);
        @(posedge clk_i); #1;
        c_req_i = 1'b0;
        checks++;
        if (!ok2 || last_len != 2) begin
            failures++;
            $display("FAIL timeout_recover: ack=%b req cycles=%0d, expected 1 and 2", ok2, last_len);
        end
    endtask

    task automatic test_timeout_race();
        int at;
        bit ok;
        mem_lat = 7; mem_rd = 32'h600DD00D;
        @(posedge clk_i); #1;
        sb.push_back('{host: 1'b0, we: 1'b0, addr: 32'h508, data: 32'h0, sel: 4'hF,
                       rdata: 32'h600DD00D, err: 1'b0});
        drive_core(1'b1, 1'b0, 32'h508, 32'h0);
        wait_ack(1'b0, 20, ok, at);
        @(posedge clk_i); #1;
        c_req_i = 1'b0;
        checks++;
        if (!ok || last_len != 8) begin
            failures++;
            $display("FAIL race_len: ack=%b req cycles=%0d, expected 1 and 8", ok, last_len);
        end
    endtask

    task automatic test_reset_mid();
        int at, rel;
        bit ok;
        mem_lat = -1; mem_rd = 32'h0;
        @(posedge clk_i); #1;
        sb.push_back('{host: 1'b1, we: 1'b0, addr: 32'h700, data: 32'h0, sel: 4'hF,
                       rdata: 32'h0, err: 1'b0});
        drive_host(1'b1, 1'b0, 32'h700, 32'h0);
        for (int i = 0; i < 5 && !mem_req_o; i++) @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_host_grant: mem_req_o=%b, expected 1", mem_req_o);
        end
        repeat (2) @(posedge clk_i);
        #3;
        drive_core(1'b1, 1'b0, 32'h704, 32'h0);
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_addr_o, h_ack_o, h_err_o, c_ack_o, c_err_o} !== '0) begin
            failures++;
            $display("FAIL rstmid_async: got req=%b addr=%h h_ack=%b, expected all 0",
                     mem_req_o, mem_addr_o, h_ack_o);
        end
        sb.delete();
        h_req_i = 1'b0;
        mem_lat = 1; mem_rd = 32'hFEEDFACE;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        rel = cyc;
        sb.push_back('{host: 1'b0, we: 1'b0, addr: 32'h704, data: 32'h0, sel: 4'hF,
                       rdata: 32'hFEEDFACE, err: 1'b0});
        wait_ack(1'b0, 20, ok, at);
        @(posedge clk_i); #1;
        c_req_i = 1'b0;
        checks++;
        if (!ok || rise_cyc != rel + 1) begin
            failures++;
            $display("FAIL rstmid_core_after: ack=%b req at %0d, expected 1 and %0d", ok, rise_cyc, rel + 1);
        end
        checks++;
        if (h_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_host_rdata: got %h, expected 0", h_rdata_o);
        end
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_contention();
        test_starvation();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        repeat (3) @(posedge clk_i);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
